// File: rtl/rr_arbiter4_pkg.sv
// rtl/rr_arbiter4_pkg.sv - shared state encodings, sizes and rotating-priority search for rr_arbiter4
package rr_arbiter4_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_NREQ         = 4;
  localparam int ARB_IDW          = 2;
  localparam int ARB_MAX_HOLD_DEF = 8;

  // Returns {found, index}: first set request starting at ptr and wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [ARB_NREQ-1:0] req,
                                         input logic [ARB_IDW-1:0]  ptr);
    logic [ARB_IDW-1:0] idx;
    logic [2:0]         res;
    res = 3'b000;
    // Walk from the farthest candidate back to ptr so the nearest hit wins.
    for (int k = ARB_NREQ - 1; k >= 0; k--) begin
      idx = ptr + ARB_IDW'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter4_dec.sv
// rtl/rr_arbiter4_dec.sv - 2-to-4 one-hot grant decoder with enable
module gnt_dec2to4
  import rr_arbiter4_pkg::*;
(
  input  logic [ARB_IDW-1:0]  gnt_id,
  input  logic                en,
  output logic [ARB_NREQ-1:0] gnt
);

  assign gnt[0] = en & (gnt_id == 2'd0);
  assign gnt[1] = en & (gnt_id == 2'd1);
  assign gnt[2] = en & (gnt_id == 2'd2);
  assign gnt[3] = en & (gnt_id == 2'd3);

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter; optional hold timeout via ARB_TIMEOUT_EN
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ARB_NREQ-1:0] req,
  output logic [ARB_NREQ-1:0] gnt,
  output logic [ARB_IDW-1:0]  gnt_id,
  output logic                gnt_valid,
  output logic                timeout
);

  // Reject hold limits the counter cannot represent.
  if (MAX_HOLD < 1 || MAX_HOLD > 15 || (1 << CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_arbiter4: MAX_HOLD must be 1..15 and below 2**CNT_W");
  end

  arb_state_e         state_q, state_d;
  logic [ARB_IDW-1:0] ptr_q, ptr_d;
  logic [ARB_IDW-1:0] gnt_id_q, gnt_id_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [2:0]         pick;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;
`endif

  // Next-state: pick a new owner in IDLE, hold or release in GRANT.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    pick        = rr_pick(req, ptr_q);
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (pick[2]) begin
          gnt_id_d    = pick[1:0];
          gnt_valid_d = 1'b1;
          state_d     = ARB_GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d  = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (!req[gnt_id_q]) begin
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_id_q + 2'd1;
          state_d     = ARB_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          // Owner overstayed: force it off and give it lowest priority next round.
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_id_q + 2'd1;
          state_d     = ARB_IDLE;
          timeout_d   = 1'b1;
        end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
          hold_cnt_d  = hold_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; reset clears all outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= 2'd0;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  gnt_dec2to4 u_dec (
    .gnt_id (gnt_id_q),
    .en     (gnt_valid_q),
    .gnt    (gnt)
  );

  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter for one shared resource.
- The grant is a 2-bit owner index. An internal 2-to-4 one-hot decoder expands it into the per-requester grant lines that drive the resource select.
- Sits between up to four lab-level requesters and a single shared datapath, for example a shared output bus or display.
- Grants are held until the owner releases. An optional hold-timeout forces release.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per owner. Used only when the timeout feature is compiled in. Legal range 1..15.
- CNT_W, 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; req[i] high means requester i wants the resource.
- gnt  output  4  one-hot grant, registered; all zeros when no owner.
- gnt_id  output  2  index of current owner; valid only when gnt_valid=1.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when an owner is forcibly released (ARB_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-grant):
  - state=IDLE, ptr=0, hold_cnt=0, gnt=4'b0000, gnt_id=2'd0, gnt_valid=0, timeout=0.
  - Outputs clear immediately, not at the next edge.
- State IDLE:
  - If req is nonzero at an edge, select the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Register it into gnt_id, set gnt_valid=1 and gnt=decode(gnt_id), hold_cnt=0, and go to GRANT.
  - Latency is 1 cycle from req sampled to gnt visible.
  - If req=0, stay in IDLE.
- State GRANT:
  - If req[gnt_id]=1, stay and increment hold_cnt, saturating.
  - If req[gnt_id]=0 (release): at the next edge clear gnt/gnt_valid, set ptr=gnt_id+1 (2-bit wrap, 3→0), and go to IDLE.
  - Exactly one idle cycle (gnt=0) separates consecutive grants. This is a fixed bus-turnaround requirement.
- Requests from non-owners during GRANT are ignored until the return to IDLE. No pre-emption.
- Simultaneous requests in IDLE are resolved by the rotating priority above; ptr points one past the last owner.
- A requester that drops req before being granted is simply not selected. No request is latched.
- gnt is always one-hot or zero. gnt_id holds its last value while gnt_valid=0.
- All outputs are driven from registers; there is no combinational path req→gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt reaches MAX_HOLD-1 while req[gnt_id] is still 1, force release at the next edge.
  - Release means gnt cleared, ptr=gnt_id+1, state IDLE, and timeout pulses high for that one cycle.
  - The forced-off owner competes normally afterwards at lowest priority.
- Undefined:
  - hold_cnt logic is removed and hold is unlimited.
  - timeout is tied to 0.

Decomposition:
- Shared include file rr_arb_defs.vh holds:
  - state encodings (ARB_IDLE=1'b0, ARB_GRANT=1'b1)
  - requester count (4) and index width (2)
  - default MAX_HOLD
- One natural sub-module: gnt_dec2to4, the purely structural 2-to-4 one-hot decoder with enable (gnt_valid) producing gnt from gnt_id.
- The top level holds the FSM, pointer, priority search and hold counter.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles → gnt=0, gnt_valid=0 throughout.
- After reset apply req=4'b1010 → next cycle gnt=4'b0010, gnt_id=1. Drop req[1] → gnt=0 for 1 cycle, then gnt=4'b1000 (ptr=2, so id 3 wins).
- All four requesting continuously with each owner releasing after 2 cycles → grant order 0,1,2,3,0, each separated by one idle cycle.
- Owner 3 releases → ptr wraps to 0; with req=4'b1001 the next grant is 4'b0001.
- Assert rst_n=0 mid-grant (gnt=4'b0100) between clock edges → gnt=0 immediately. After release, req=4'b0100 grants id 2 again (ptr=0 search).
- ARB_TIMEOUT_EN, MAX_HOLD=4, req[0] held high with req[2] also high:
  - gnt[0] holds for 4 cycles, then timeout=1 for one cycle with gnt=0.
  - Next cycle gnt=4'b0100.
